// File: rtl/vector_pkg.sv
// Shared definitions for the vector lane dispatcher: sizes, FSM states, ALU opcodes.
package vector_pkg;

    localparam int unsigned LEN              = 32;
    localparam int unsigned VECTOR_SIZE      = 8;
    localparam int unsigned ENTRY_INDEX_SIZE = 3;
    localparam int unsigned LANE_SIZE        = 4;
    localparam int unsigned OP_WIDTH         = 4;
    localparam int unsigned LANE_SHIFT       = $clog2(LANE_SIZE);

    // Vector length / group counter type: one bit wider than an element index.
    typedef logic [ENTRY_INDEX_SIZE:0] vlen_t;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_ISSUE,
        DISP_DONE
    } disp_state_e;

    localparam logic [OP_WIDTH-1:0] ALU_ADD = 4'h0;
    localparam logic [OP_WIDTH-1:0] ALU_SUB = 4'h1;
    localparam logic [OP_WIDTH-1:0] ALU_AND = 4'h2;
    localparam logic [OP_WIDTH-1:0] ALU_OR  = 4'h3;
    localparam logic [OP_WIDTH-1:0] ALU_XOR = 4'h4;

    // Requested lengths beyond the register size are clamped.
    function automatic vlen_t clamp_vl(input vlen_t vl);
        return (vl > vlen_t'(VECTOR_SIZE)) ? vlen_t'(VECTOR_SIZE) : vl;
    endfunction

    // Number of lane groups needed to cover vl_eff elements.
    function automatic vlen_t num_groups(input vlen_t vl_eff);
        return (vl_eff + vlen_t'(LANE_SIZE - 1)) >> LANE_SHIFT;
    endfunction

endpackage

// File: rtl/vector_lane_dispatcher_if.sv
// Request, lane and writeback signals of the vector lane dispatcher.
interface vector_lane_dispatcher_if;
    import vector_pkg::*;

    logic                          start_valid;
    logic                          start_ready;
    logic [OP_WIDTH-1:0]           op_code;
    logic [VECTOR_SIZE*LEN-1:0]    vs1_data;
    logic [VECTOR_SIZE*LEN-1:0]    vs2_data;
    logic [LEN-1:0]                scalar_data;
    logic                          use_scalar;
    logic [ENTRY_INDEX_SIZE:0]     vl;
    logic                          vm;
    logic [VECTOR_SIZE-1:0]        mask;
    logic [LANE_SIZE-1:0]          lane_valid;
    logic [OP_WIDTH-1:0]           lane_op_code;
    logic [LANE_SIZE*LEN-1:0]      lane_op1;
    logic [LANE_SIZE*LEN-1:0]      lane_op2;
    logic [LANE_SIZE*LEN-1:0]      lane_result;
    logic                          done;
    logic [VECTOR_SIZE*LEN-1:0]    vd_data;
    logic [VECTOR_SIZE-1:0]        vd_we_mask;

    // Requester / lane-ALU side.
    modport master (
        output start_valid, op_code, vs1_data, vs2_data, scalar_data, use_scalar, vl, vm, mask,
        output lane_result,
        input  start_ready, lane_valid, lane_op_code, lane_op1, lane_op2, done, vd_data,
        input  vd_we_mask
    );

    // Dispatcher side.
    modport slave (
        input  start_valid, op_code, vs1_data, vs2_data, scalar_data, use_scalar, vl, vm, mask,
        input  lane_result,
        output start_ready, lane_valid, lane_op_code, lane_op1, lane_op2, done, vd_data,
        output vd_we_mask
    );

endinterface

// File: rtl/lane_operand_select.sv
// Per-lane element selection: element index, issue strobe and operands for group g.
module lane_operand_select
    import vector_pkg::*;
#(
    parameter int unsigned LANE_IDX = 0
) (
    input  logic                          active,
    input  vlen_t                         g,
    input  vlen_t                         vl_eff,
    input  logic                          vm,
    input  logic [VECTOR_SIZE-1:0]        mask,
    input  logic                          use_scalar,
    input  logic [LEN-1:0]                scalar_data,
    input  logic [VECTOR_SIZE*LEN-1:0]    vs1_data,
    input  logic [VECTOR_SIZE*LEN-1:0]    vs2_data,
    output logic [ENTRY_INDEX_SIZE-1:0]   elem,
    output logic                          valid,
    output logic [LEN-1:0]                op1,
    output logic [LEN-1:0]                op2
);

    vlen_t e_wide;

    // Element e = g*LANE_SIZE + LANE_IDX; inactive lanes drive zero operands.
    always_comb begin
        e_wide = (g << LANE_SHIFT) + vlen_t'(LANE_IDX);
        elem   = e_wide[ENTRY_INDEX_SIZE-1:0];
        valid  = active && (e_wide < vl_eff) && (vm || mask[elem]);
        op1    = '0;
        op2    = '0;
        if (valid) begin
            op1 = vs1_data[elem*LEN +: LEN];
            op2 = use_scalar ? scalar_data : vs2_data[elem*LEN +: LEN];
        end
    end

endmodule

// File: rtl/vector_lane_dispatcher.sv
// Issues one vector operation to the ALU lanes group by group and gathers the results.
module vector_lane_dispatcher
    import vector_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    vector_lane_dispatcher_if.slave bus
);

    disp_state_e                  state;
    vlen_t                        g;
    vlen_t                        vl_eff_q;
    logic [OP_WIDTH-1:0]          op_code_q;
    logic [VECTOR_SIZE*LEN-1:0]   vs1_q;
    logic [VECTOR_SIZE*LEN-1:0]   vs2_q;
    logic [LEN-1:0]               scalar_q;
    logic                         use_scalar_q;
    logic                         vm_q;
    logic [VECTOR_SIZE-1:0]       mask_q;
    logic                         done_q;
    logic [VECTOR_SIZE*LEN-1:0]   vd_q;
    logic [VECTOR_SIZE-1:0]       we_q;

    logic                         issuing;
    logic [ENTRY_INDEX_SIZE-1:0]  elem [LANE_SIZE];
    logic [LANE_SIZE-1:0]         lane_valid;
    logic [LANE_SIZE*LEN-1:0]     lane_op1;
    logic [LANE_SIZE*LEN-1:0]     lane_op2;
    vlen_t                        start_vl_eff;
    vlen_t                        groups;

    assign issuing      = (state == DISP_ISSUE);
    assign start_vl_eff = clamp_vl(bus.vl);
    assign groups       = num_groups(vl_eff_q);

    for (genvar i = 0; i < LANE_SIZE; i++) begin : g_lane
        lane_operand_select #(
            .LANE_IDX (i)
        ) u_sel (
            .active      (issuing),
            .g           (g),
            .vl_eff      (vl_eff_q),
            .vm          (vm_q),
            .mask        (mask_q),
            .use_scalar  (use_scalar_q),
            .scalar_data (scalar_q),
            .vs1_data    (vs1_q),
            .vs2_data    (vs2_q),
            .elem        (elem[i]),
            .valid       (lane_valid[i]),
            .op1         (lane_op1[i*LEN +: LEN]),
            .op2         (lane_op2[i*LEN +: LEN])
        );
    end

    assign bus.start_ready  = (state == DISP_IDLE);
    assign bus.lane_valid   = lane_valid;
    assign bus.lane_op_code = issuing ? op_code_q : '0;
    assign bus.lane_op1     = lane_op1;
    assign bus.lane_op2     = lane_op2;
    assign bus.done         = done_q;
    assign bus.vd_data      = vd_q;
    assign bus.vd_we_mask   = we_q;

    // Control FSM, operand capture and result gathering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= DISP_IDLE;
            g            <= '0;
            vl_eff_q     <= '0;
            op_code_q    <= '0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            scalar_q     <= '0;
            use_scalar_q <= 1'b0;
            vm_q         <= 1'b0;
            mask_q       <= '0;
            done_q       <= 1'b0;
            vd_q         <= '0;
            we_q         <= '0;
        end else begin
            case (state)
                DISP_IDLE: begin
                    if (bus.start_valid) begin
                        op_code_q    <= bus.op_code;
                        vs1_q        <= bus.vs1_data;
                        vs2_q        <= bus.vs2_data;
                        scalar_q     <= bus.scalar_data;
                        use_scalar_q <= bus.use_scalar;
                        vm_q         <= bus.vm;
                        mask_q       <= bus.mask;
                        vl_eff_q     <= start_vl_eff;
                        g            <= '0;
                        vd_q         <= '0;
                        we_q         <= '0;
                        // An empty operation skips straight to completion.
                        if (start_vl_eff == '0) begin
                            state  <= DISP_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= DISP_ISSUE;
                        end
                    end
                end
                DISP_ISSUE: begin
                    for (int i = 0; i < LANE_SIZE; i++) begin
                        if (lane_valid[i]) begin
                            vd_q[int'(elem[i])*LEN +: LEN] <= bus.lane_result[i*LEN +: LEN];
                            we_q[elem[i]]                  <= 1'b1;
                        end
                    end
                    g <= g + 1'b1;
                    if (g == groups - 1'b1) begin
                        state  <= DISP_DONE;
                        done_q <= 1'b1;
                    end
                end
                DISP_DONE: begin
                    done_q <= 1'b0;
                    state  <= DISP_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= DISP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_lane_dispatcher.sv
// Self-checking bench for vector_lane_dispatcher: directed table, random ops, corner sequences.
module tb_vector_lane_dispatcher;
    import vector_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_lane_dispatcher_if bus();

    vector_lane_dispatcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [OP_WIDTH-1:0]        op;
        vlen_t                      vl;
        logic                       vm;
        logic [VECTOR_SIZE-1:0]     mask;
        logic                       use_scalar;
        logic [LEN-1:0]             scalar;
        logic [VECTOR_SIZE*LEN-1:0] vs1;
        logic [VECTOR_SIZE*LEN-1:0] vs2;
    } req_t;

    typedef struct {
        string                      name;
        req_t                       req;
        logic [LANE_SIZE-1:0]       lv0;
        logic [LANE_SIZE-1:0]       lv1;
        logic [VECTOR_SIZE-1:0]     we;
        int                         lat;
    } vec_t;

    // Lane ALU stand-in.
    function automatic logic [LEN-1:0] alu(input logic [OP_WIDTH-1:0] op,
                                           input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        bus.lane_result = '0;
        for (int i = 0; i < LANE_SIZE; i++)
            bus.lane_result[i*LEN +: LEN] = alu(bus.lane_op_code, bus.lane_op1[i*LEN +: LEN],
                                                bus.lane_op2[i*LEN +: LEN]);
    end

    // Reference model: element-level view of the operation.
    function automatic int eff_len(input req_t r);
        return (int'(r.vl) > VECTOR_SIZE) ? VECTOR_SIZE : int'(r.vl);
    endfunction

    function automatic bit elem_on(input req_t r, input int e);
        return (e < eff_len(r)) && (r.vm || r.mask[e]);
    endfunction

    function automatic logic [LEN-1:0] src2(input req_t r, input int e);
        return r.use_scalar ? r.scalar : r.vs2[e*LEN +: LEN];
    endfunction

    function automatic logic [VECTOR_SIZE*LEN-1:0] model_vd(input req_t r);
        logic [VECTOR_SIZE*LEN-1:0] v = '0;
        for (int e = 0; e < VECTOR_SIZE; e++)
            if (elem_on(r, e)) v[e*LEN +: LEN] = alu(r.op, r.vs1[e*LEN +: LEN], src2(r, e));
        return v;
    endfunction

    function automatic logic [VECTOR_SIZE-1:0] model_we(input req_t r);
        logic [VECTOR_SIZE-1:0] m = '0;
        for (int e = 0; e < VECTOR_SIZE; e++) m[e] = elem_on(r, e);
        return m;
    endfunction

    function automatic logic [LANE_SIZE-1:0] model_lv(input req_t r, input int grp);
        logic [LANE_SIZE-1:0] m = '0;
        for (int i = 0; i < LANE_SIZE; i++) m[i] = elem_on(r, grp * LANE_SIZE + i);
        return m;
    endfunction

    function automatic int model_lat(input req_t r);
        return (eff_len(r) + LANE_SIZE - 1) / LANE_SIZE + 1;
    endfunction

    function automatic req_t base_req();
        req_t r;
        r.op = ALU_ADD; r.vl = 4'd8; r.vm = 1'b1; r.mask = '0;
        r.use_scalar = 1'b0; r.scalar = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            r.vs1[i*LEN +: LEN] = LEN'(i);
            r.vs2[i*LEN +: LEN] = LEN'(10);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_req(input req_t r);
        bus.op_code     = r.op;
        bus.vl          = r.vl;
        bus.vm          = r.vm;
        bus.mask        = r.mask;
        bus.use_scalar  = r.use_scalar;
        bus.scalar_data = r.scalar;
        bus.vs1_data    = r.vs1;
        bus.vs2_data    = r.vs2;
    endtask

    // Issue one operation and check lanes per cycle, done latency and the writeback.
    task automatic run_op(input string name, input req_t r, input logic [LANE_SIZE-1:0] lv0,
                          input logic [LANE_SIZE-1:0] lv1, input logic [VECTOR_SIZE-1:0] we,
                          input int lat);
        int got_done;
        logic [LANE_SIZE-1:0] lv;
        logic [2*LANE_SIZE*LEN-1:0] exp_ops;
        @(negedge clk);
        drive_req(r);
        bus.start_valid = 1'b1;
        check({name, " ready"}, 256'(bus.start_ready), 256'(1));
        @(posedge clk);
        #1 bus.start_valid = 1'b0;
        got_done = -1;
        for (int k = 1; k <= 8 && got_done < 0; k++) begin
            @(negedge clk);
            if (bus.done) got_done = k;
            lv = (k >= lat) ? '0 : ((k == 1) ? lv0 : lv1);
            check({name, " lane_valid"}, 256'(bus.lane_valid), 256'(lv));
            exp_ops = '0;
            for (int i = 0; i < LANE_SIZE; i++) begin
                if (lv[i]) begin
                    exp_ops[LANE_SIZE*LEN + i*LEN +: LEN] = r.vs1[((k-1)*LANE_SIZE+i)*LEN +: LEN];
                    exp_ops[i*LEN +: LEN] = src2(r, (k-1)*LANE_SIZE + i);
                end
            end
            check({name, " operands"}, 256'({bus.lane_op1, bus.lane_op2}), 256'(exp_ops));
            if (lv != '0) check({name, " opcode"}, 256'(bus.lane_op_code), 256'(r.op));
        end
        check({name, " done_cycle"}, 256'(got_done), 256'(lat));
        check({name, " we_mask"}, 256'(bus.vd_we_mask), 256'(we));
        check({name, " vd"}, bus.vd_data, model_vd(r));
        @(negedge clk);
        check({name, " after_done"}, 256'({bus.done, bus.start_ready}), 256'(2'b01));
        check({name, " vd_hold"}, bus.vd_data, model_vd(r));
    endtask

    vec_t tbl [6];

    initial begin
        req_t r;
        int   ready_cnt, done_cnt, bad, done_seen;

        bus.start_valid = 1'b0;
        drive_req(base_req());
        rst = 1'b1;
        #12;
        check("reset ready/done", 256'({bus.start_ready, bus.done}), 256'(2'b10));
        check("reset we_mask", 256'(bus.vd_we_mask), 256'(0));
        check("reset vd", bus.vd_data, 256'(0));
        check("reset lane_valid", 256'(bus.lane_valid), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        tbl[0].name = "full_add";  tbl[0].req = base_req();
        tbl[0].lv0 = 4'b1111; tbl[0].lv1 = 4'b1111; tbl[0].we = 8'hFF; tbl[0].lat = 3;
        tbl[1].name = "masked";    tbl[1].req = base_req();
        tbl[1].req.vl = 4'd5; tbl[1].req.vm = 1'b0; tbl[1].req.mask = 8'b0001_0110;
        tbl[1].lv0 = 4'b0110; tbl[1].lv1 = 4'b0001; tbl[1].we = 8'h16; tbl[1].lat = 3;
        tbl[2].name = "scalar";    tbl[2].req = base_req();
        tbl[2].req.vl = 4'd4; tbl[2].req.use_scalar = 1'b1; tbl[2].req.scalar = 32'hFFFF_FFFF;
        tbl[2].lv0 = 4'b1111; tbl[2].lv1 = 4'b0000; tbl[2].we = 8'h0F; tbl[2].lat = 2;
        tbl[3].name = "vl0";       tbl[3].req = base_req();
        tbl[3].req.vl = 4'd0;
        tbl[3].lv0 = 4'b0000; tbl[3].lv1 = 4'b0000; tbl[3].we = 8'h00; tbl[3].lat = 1;
        tbl[4].name = "vl15";      tbl[4].req = base_req();
        tbl[4].req.vl = 4'd15;
        tbl[4].lv0 = 4'b1111; tbl[4].lv1 = 4'b1111; tbl[4].we = 8'hFF; tbl[4].lat = 3;
        tbl[5].name = "xor_vl3";   tbl[5].req = base_req();
        tbl[5].req.vl = 4'd3; tbl[5].req.vm = 1'b0; tbl[5].req.mask = 8'hFF;
        tbl[5].req.op = ALU_XOR;
        tbl[5].lv0 = 4'b0111; tbl[5].lv1 = 4'b0000; tbl[5].we = 8'h07; tbl[5].lat = 2;

        for (int t = 0; t < 6; t++)
            run_op(tbl[t].name, tbl[t].req, tbl[t].lv0, tbl[t].lv1, tbl[t].we, tbl[t].lat);

        // Random operations against the model.
        for (int n = 0; n < 24; n++) begin
            r.op         = OP_WIDTH'($urandom_range(0, 4));
            r.vl         = vlen_t'($urandom_range(0, 15));
            r.vm         = 1'($urandom_range(0, 1));
            r.mask       = VECTOR_SIZE'($urandom);
            r.use_scalar = 1'($urandom_range(0, 1));
            r.scalar     = $urandom;
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                r.vs1[i*LEN +: LEN] = $urandom;
                r.vs2[i*LEN +: LEN] = $urandom;
            end
            run_op("random", r, model_lv(r, 0), model_lv(r, 1), model_we(r), model_lat(r));
        end

        // Continuous request: one acceptance per IDLE visit, never ready while busy.
        drive_req(base_req());
        bus.start_valid = 1'b1;
        ready_cnt = 0; done_cnt = 0; bad = 0;
        for (int n = 0; n < 12; n++) begin
            if (bus.start_ready) ready_cnt++;
            if (bus.done) done_cnt++;
            if (bus.start_ready && (bus.done || bus.lane_valid != '0)) bad++;
            @(negedge clk);
        end
        bus.start_valid = 1'b0;
        check("hold ready_count", 256'(ready_cnt), 256'(3));
        check("hold done_count", 256'(done_cnt), 256'(3));
        check("hold ready_while_busy", 256'(bad), 256'(0));
        @(negedge clk);
        check("hold idle_after", 256'(bus.start_ready), 256'(1));

        // Reset during the first ISSUE cycle.
        @(negedge clk);
        drive_req(base_req());
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1 bus.start_valid = 1'b0;
        @(negedge clk);
        check("rst issuing", 256'(bus.lane_valid), 256'(4'b1111));
        rst = 1'b1;
        #1;
        check("rst state", 256'({bus.start_ready, bus.done, bus.lane_valid}), 256'(6'b100000));
        check("rst we_mask", 256'(bus.vd_we_mask), 256'(0));
        check("rst vd", bus.vd_data, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("rst no_done", 256'(done_seen), 256'(0));
        check("rst ready_after", 256'(bus.start_ready), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_lane_dispatcher.md
# vector_lane_dispatcher

Sequencer directly upstream of the per-lane vector ALUs. It accepts one vector operation (two source vectors, or one vector plus a scalar), issues element pairs to `LANE_SIZE` ALU lanes in groups over successive cycles, and captures the lane results into a destination vector with a per-element write mask for register-file writeback. It is the only block that drives the lane ALU operand inputs.

## Interface
- `LEN`, 32, element width in bits
- `VECTOR_SIZE`, 8, elements per vector register
- `ENTRY_INDEX_SIZE`, 3, log2(`VECTOR_SIZE`)
- `LANE_SIZE`, 4, number of ALU lanes; a power of two that divides `VECTOR_SIZE`
- `OP_WIDTH`, 4, ALU opcode width

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start_valid`  in  1  operation request
- `start_ready`  out  1  `(state==IDLE)`
- `op_code`  in  `OP_WIDTH`  ALU operation; passed through to the lanes unchanged
- `vs1_data`  in  `VECTOR_SIZE*LEN`  source 1; element i is at `[i*LEN +: LEN]`
- `vs2_data`  in  `VECTOR_SIZE*LEN`  source 2
- `scalar_data`  in  `LEN`  scalar operand
- `use_scalar`  in  1  when 1, op2 = `scalar_data` for every element
- `vl`  in  `ENTRY_INDEX_SIZE+1`  active vector length
- `vm`  in  1  when 1, masking is disabled
- `mask`  in  `VECTOR_SIZE`  per-element enable, used when `vm`=0
- `lane_valid`  out  `LANE_SIZE`  per-lane issue strobe
- `lane_op_code`  out  `OP_WIDTH`  opcode to all lanes
- `lane_op1`, `lane_op2`  out  `LANE_SIZE*LEN`  lane operands
- `lane_result`  in  `LANE_SIZE*LEN`  combinational lane results for the same cycle
- `done`  out  1  one-cycle completion pulse
- `vd_data`  out  `VECTOR_SIZE*LEN`  assembled result
- `vd_we_mask`  out  `VECTOR_SIZE`  per-element write enable

## Operation
- States: IDLE, ISSUE, DONE.
- Accept on a rising edge when `start_valid && start_ready`. At acceptance, register `op_code`, the operands, `use_scalar`, `vm` and `mask`. Register `vl` clamped to `VECTOR_SIZE` (`vl_eff`). Clear `vd_data` and `vd_we_mask`, and set group counter `g`=0.
- `G = ceil(vl_eff / LANE_SIZE)`.
  - G=0: IDLE -> DONE.
  - Otherwise: IDLE -> ISSUE.
- In ISSUE, lane i handles element `e = g*LANE_SIZE + i`.
  - `lane_valid[i] = (e < vl_eff) && (vm || mask[e])`.
  - `lane_op1[i] = vs1[e]`.
  - `lane_op2[i] = use_scalar ? scalar : vs2[e]`.
  - Each edge: for every valid lane, write `vd_data[e] <= lane_result[i]` and `vd_we_mask[e] <= 1`.
  - Increment `g`. Leave for DONE when `g == G-1`.
- Invalid lanes:
  - Operands are driven to 0.
  - Their element positions keep `vd_data`=0 and `vd_we_mask`=0 (tail- and mask-undisturbed at writeback).
- DONE: `done`=1 for exactly one cycle, then -> IDLE. `vd_data` and `vd_we_mask` hold their values until the next acceptance.
- `start_valid` outside IDLE is ignored; no request is queued.

## Timing
- Reset values (asynchronous): state=IDLE, `g`=0, `done`=0, `vd_data`=0, `vd_we_mask`=0, all registered operands 0. `start_ready` is therefore 1.
- `lane_*` outputs are combinational from state, `g` and the registered operands. Outside ISSUE they are 0.
- Latency: acceptance edge T. ISSUE occupies cycles T+1..T+G. `done` is high in cycle T+G+1. The next acceptance is possible at edge T+G+2.
- Example: `vl`=8, `LANE_SIZE`=4 gives G=2 and `done` at T+3. `vl`=0 gives `done` at T+1.
- `rst` asserted mid-ISSUE: the operation is abandoned immediately, `done` never pulses, and outputs clear.

## Structure
- Shared package `vector_pkg`:
  - state encoding (`DISP_IDLE`, `DISP_ISSUE`, `DISP_DONE`)
  - `LEN`, `VECTOR_SIZE`, `ENTRY_INDEX_SIZE`, `LANE_SIZE`, `OP_WIDTH` defaults
  - ALU opcode constants
- Natural sub-module: `lane_operand_select`. It is combinational, one instance per lane, and produces the element index, valid, op1 and op2 for a given `g`.
- Everything else is a single flat FSM plus result registers.

## Test plan
- Full add: `vl`=8, `vm`=1, vs1[i]=i, vs2[i]=10, lane model adds. Required: `lane_valid`=4'b1111 in T+1 and T+2, `done` at T+3, vd[i]=i+10, `vd_we_mask`=8'hFF.
- Masked/short: `vl`=5, `vm`=0, `mask`=8'b0001_0110. Required: `lane_valid`=4'b0110 then 4'b0001, `vd_we_mask`=8'h16, other elements 0.
- Scalar: `use_scalar`=1, `scalar_data`=32'hFFFF_FFFF, `vl`=4. Required: every valid `lane_op2`=32'hFFFF_FFFF, G=1, `done` at T+2.
- Boundaries:
  - `vl`=0: `done` at T+1, `vd_we_mask`=0, no `lane_valid`.
  - `vl`=15: clamped to 8, result identical to `vl`=8.
- Handshake: hold `start_valid`=1 continuously. Required: `start_ready`=0 during ISSUE and DONE, and exactly one acceptance per IDLE cycle.
- Reset mid-operation: assert `rst` in the first ISSUE cycle. Required: state IDLE, `vd_we_mask`=0, no `done` pulse, `start_ready`=1 after release.
